// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// An owner keeps the port for up to BURST words; full stalls without releasing.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                      wr_clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic                      full,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           grant,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      write,
    output logic [WIDTH-1:0]          data_in
);

    localparam int OWN_W = $clog2(NREQ);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state;
    logic [OWN_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;
    logic               pick_valid;
    logic [OWN_W-1:0]   pick_idx;
    logic [OWN_W-1:0]   next_ptr;
    logic               owner_req;

    // Walk downward so the candidate closest to ptr is the last one assigned.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                pick_valid = 1'b1;
                pick_idx   = OWN_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign next_ptr  = (owner == OWN_W'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign owner_req = req[owner];
    assign write     = (state == GRANT) && owner_req && !full;
    assign ack       = write ? grant : '0;
    assign data_in   = req_data[int'(owner)*WIDTH +: WIDTH];

    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        grant <= NREQ'(1) << pick_idx;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // A dropped request or a finished burst hands the port back.
                    if (!owner_req || (!full && cnt == LAST)) begin
                        ptr   <= next_ptr;
                        grant <= '0;
                        owner <= '0;
                        state <= IDLE;
                    end else if (!full) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed literal scenarios plus randomized traffic
// checked every cycle against a behavioural round-robin model.
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  wr_clk   = 1'b0;
    logic                  reset    = 1'b0;
    logic [NREQ-1:0]       req      = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic                  full     = 1'b0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       grant;
    logic [1:0]            owner;
    logic                  write;
    logic [WIDTH-1:0]      data_in;

    int checks = 0;
    int errors = 0;

    // Model: m_own is -1 when nobody holds the port.
    int m_own = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
        .wr_clk   (wr_clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .full     (full),
        .ack      (ack),
        .grant    (grant),
        .owner    (owner),
        .write    (write),
        .data_in  (data_in)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            m_own <= -1;
            m_ptr <= 0;
            m_cnt <= 0;
        end else if (m_own < 0) begin
            if (req != 0) begin
                m_own <= pick(m_ptr, req);
                m_cnt <= 0;
            end
        end else if (!req[m_own]) begin
            m_ptr <= (m_own + 1) % NREQ;
            m_own <= -1;
        end else if (!full) begin
            if (m_cnt + 1 == BURST) begin
                m_ptr <= (m_own + 1) % NREQ;
                m_own <= -1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge wr_clk) begin : compare
        int   o;
        logic ew;
        o  = (m_own < 0) ? 0 : m_own;
        ew = (m_own >= 0) && req[o] && !full;
        check("grant",   grant,   (m_own < 0) ? 0 : (1 << m_own));
        check("owner",   owner,   o);
        check("write",   write,   ew);
        check("ack",     ack,     ew ? (1 << o) : 0);
        check("data_in", data_in, req_data[o*WIDTH +: WIDTH]);
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge wr_clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_write", write, 0);
        check("async_rst_ack",   ack,   0);
        @(posedge wr_clk);
        #1 reset = 1'b1;
    endtask

    // Requesters keep req and data stable until acked, then pick a new word or go quiet.
    task automatic drive_reqs(input logic [NREQ-1:0] acked, input int keep_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || acked[i]) begin
                if ($urandom_range(0, 99) < keep_pct) begin
                    req[i] = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [7:0]       words [5];
        logic [7:0]       got   [5];
        logic [7:0]       wpat;
        logic [NREQ-1:0]  a;
        logic [NREQ-1:0]  pg;
        int               wi, gi, ng, bw, ackbad;
        int               gs [6];
        int               bws[6];
        bit               adv, rst_done;

        // Reset held with every request asserted.
        req = 4'b1111;
        repeat (3) @(posedge wr_clk);
        #1;
        check("hold_grant", grant, 0);
        check("hold_write", write, 0);
        check("hold_ack",   ack,   0);
        @(negedge wr_clk);
        reset = 1'b1;
        tick();
        check("first_grant", grant, 4'b0001);
        req = '0;
        repeat (3) tick();

        // Single requester 2: A1..D4 as one burst, one idle cycle, then E5.
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
        words[3] = 8'hD4; words[4] = 8'hE5;
        wi = 0; gi = 0; ackbad = 0; wpat = '0;
        req[2] = 1'b1;
        req_data[2*WIDTH +: WIDTH] = words[0];
        for (int n = 0; n < 8; n++) begin
            @(negedge wr_clk);
            wpat[n] = write;
            adv = write;
            if (write) begin
                if (gi < 5) got[gi] = data_in;
                gi++;
                if (ack != 4'b0100) ackbad++;
            end
            tick();
            if (adv) begin
                wi++;
                if (wi < 5) req_data[2*WIDTH +: WIDTH] = words[wi];
                else req[2] = 1'b0;
            end
        end
        check("single_pattern", wpat, 8'h5E);
        check("single_count",   gi,   5);
        check("single_ack",     ackbad, 0);
        for (int i = 0; i < 5; i++) check("single_word", got[i], words[i]);
        repeat (2) tick();

        // Owner 0 drops after one word while requester 3 waits.
        pulse_reset();
        req = 4'b1001;
        req_data[0 +: WIDTH]       = 8'h11;
        req_data[3*WIDTH +: WIDTH] = 8'h33;
        tick();
        check("drop_grant0", grant, 4'b0001);
        @(negedge wr_clk);
        check("drop_write",  write,   1);
        check("drop_data",   data_in, 8'h11);
        tick();
        req[0] = 1'b0;
        check("drop_hold", grant, 4'b0001);
        @(negedge wr_clk);
        check("drop_nowrite", write, 0);
        tick();
        check("drop_idle",  grant, 0);
        tick();
        check("drop_grant3", grant, 4'b1000);
        check("drop_owner3", owner, 3);
        req = '0;
        repeat (3) tick();

        // All requesters busy: 0,1,2,3,0 with BURST words each.
        pulse_reset();
        drive_reqs('0, 100);
        ng = 0; bw = 0; pg = '0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge wr_clk);
            if (grant != 0 && pg == 0) begin
                if (ng > 0) bws[ng-1] = bw;
                gs[ng] = owner;
                ng++;
                bw = 0;
            end
            if (write) bw++;
            pg = grant;
            a  = ack;
            tick();
            drive_reqs(a, 100);
        end
        check("rr_grants", ng, 6);
        for (int i = 0; i < 5; i++) begin
            check("rr_owner", gs[i], i % NREQ);
            check("rr_burst", bws[i], BURST);
        end
        req = '0;
        repeat (3) tick();

        // Random traffic with random full and one asynchronous reset mid-burst.
        rst_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge wr_clk);
            a = ack;
            tick();
            drive_reqs(a, 70);
            full = ($urandom_range(0, 99) < 20);
            if (c >= 1500 && !rst_done && grant != 0) begin
                #2 reset = 1'b0;
                #1;
                check("mid_rst_grant", grant, 0);
                check("mid_rst_write", write, 0);
                check("mid_rst_ack",   ack,   0);
                tick();
                reset = 1'b1;
                rst_done = 1'b1;
            end
        end
        check("mid_rst_done", rst_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
